time_set_controller: RTL
========================

// Module: time_set_controller
// PURPOSE
//  Button-driven sequencer for the clock's time-entry datapath: walks seconds -> minutes -> hours,
//  drives mode/val into the time-entry register block, then pulses switch to apply the new time.
//  Sits between debounced front-panel buttons and the time-entry block; field values preload
//  from the running clock. Edit abandoned on cancel or inactivity timeout.
// PARAMETERS
//  HR_MAX      23         largest hours value; wraps to 0
//  MS_MAX      59         largest minutes/seconds value; wraps to 0
//  TIMEOUT     32'd500000 idle clk cycles in an edit state before auto-cancel (>=2)
//  BLINK_DIV   32'd25000  clk cycles per blink half-period (BLINK_EN only, >=1)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  btn_set     in   1  1-cycle pulse: start edit (IDLE only)
//  btn_next    in   1  1-cycle pulse: accept field, advance
//  btn_up      in   1  1-cycle pulse: field +1
//  btn_down    in   1  1-cycle pulse: field -1
//  btn_cancel  in   1  1-cycle pulse: abort edit, no apply
//  cur_hrs     in   5  running-clock hours (preload)
//  cur_min     in   6  running-clock minutes (preload)
//  cur_sec     in   6  running-clock seconds (preload)
//  mode        out  3  0 idle, 1 seconds, 2 minutes, 3 hours (time-entry field select)
//  val         out  6  value for selected field; 0 when mode=0
//  switch      out  1  apply strobe to time-entry block, high exactly 1 cycle
//  editing     out  1  high in SEC/MIN/HRS states
//  blink       out  1  field-blank strobe for display (0 when BLINK_EN undefined)
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, mode=0, val=0, switch=0, editing=0, blink=0,
//    timeout counter 0, blink counter 0.
//  - States: IDLE, SEC, MIN, HRS, APPLY. mode = 1/2/3 in SEC/MIN/HRS, 0 in IDLE/APPLY.
//  - IDLE: btn_set -> SEC next cycle, val <= cur_sec. Other buttons ignored.
//  - SEC: btn_next -> MIN, val <= cur_min. MIN: btn_next -> HRS, val <= {1'b0,cur_hrs}.
//  - HRS: btn_next -> APPLY. APPLY: switch=1 for that single cycle, then IDLE unconditionally.
//  - The time-entry block latches val while mode selects the field, so each
//    accepted field is captured before advancing; no per-field storage here.
//  - btn_up: val = (val==MAX) ? 0 : val+1. btn_down: val = (val==0) ? MAX : val-1.
//    MAX = MS_MAX in SEC/MIN, HR_MAX in HRS. Field update visible cycle after pulse.
//  - Simultaneous pulses, priority: btn_cancel > btn_next > (btn_up & btn_down = no change) >
//    btn_up / btn_down. Losing pulses discarded, not queued.
//  - btn_cancel in SEC/MIN/HRS -> IDLE next cycle, val=0, no switch pulse. Fields already
//    latched by the time-entry block stay latched; running time unchanged since no apply.
//  - Timeout: counter clears on any button pulse or state change; counts in SEC/MIN/HRS;
//    reaching TIMEOUT-1 behaves as btn_cancel. Counter held at 0 in IDLE/APPLY.
//  - Out-of-range preload (cur_* > MAX) passes through; first up wraps to 0, down gives val-1.
//  - Reset mid-edit: immediate return to reset values; switch never glitches high.
// CONFIGURATION
//  BLINK_EN defined: blink toggles every BLINK_DIV cycles while editing=1; forced 0 and
//   counter cleared when editing=0 and on any btn_up/btn_down (field shows solid on change).
//  BLINK_EN undefined: blink tied 0, no blink counter synthesised.
// TESTING
//  1 Reset then btn_set with cur=12:34:56 -> mode=1,val=56; next -> mode=2,val=34; next ->
//    mode=3,val=12; next -> mode=0, switch=1 one cycle, then IDLE.
//  2 SEC val=59, btn_up -> 0; btn_down -> 59; HRS val=23 up -> 0, down from 0 -> 23.
//  3 btn_up+btn_down same cycle -> val unchanged; btn_next+btn_up -> advances, val=preload.
//  4 btn_cancel in MIN -> IDLE, mode=0, val=0, switch never asserted across 20 cycles.
//  5 TIMEOUT=8, enter SEC, no buttons -> IDLE after 8 cycles, no switch; a btn_up at cycle 5
//    restarts count.
//  6 rst_n low mid-HRS -> all outputs 0 asynchronously; with BLINK_EN, BLINK_DIV=4 -> blink
//    period 8 cycles while editing, 0 in IDLE.

Source files
------------

// File: rtl/time_set_controller.sv
// -----------------------------------------------------------------------------
// time_set_controller
//
// Purpose:
//   Button-driven sequencer for the clock's time-entry datapath. It walks the
//   operator through seconds, then minutes, then hours. It presents the field
//   select (mode) and field value (val) to the time-entry register block. It
//   then issues a one-cycle apply strobe (switch).
//
//   Field values preload from the running clock on entry to each field. An
//   edit is abandoned on btn_cancel or after TIMEOUT idle cycles.
//
// Optional feature:
//   BLINK_EN - when defined, blink toggles every BLINK_DIV cycles while
//              editing, giving the display a field-blank strobe. When
//              undefined, blink is tied low and no blink counter exists.
//
// Parameters:
//   HR_MAX     largest hours value (wraps to 0)
//   MS_MAX     largest minutes/seconds value (wraps to 0)
//   TIMEOUT    idle clk cycles in an edit state before auto-cancel (>=2)
//   BLINK_DIV  clk cycles per blink half-period (>=1, BLINK_EN only)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   btn_set                 start edit (honoured in IDLE only)
//   btn_next                accept field and advance
//   btn_up / btn_down       field +1 / -1 with wrap
//   btn_cancel              abort edit without apply
//   cur_hrs/cur_min/cur_sec running-clock time used as preload
//   mode                    0 idle, 1 seconds, 2 minutes, 3 hours
//   val                     value of the selected field, 0 when mode=0
//   switch                  one-cycle apply strobe
//   editing                 high while a field is being edited
//   blink                   display field-blank strobe
// -----------------------------------------------------------------------------
module time_set_controller #(
    parameter int unsigned HR_MAX    = 23,
    parameter int unsigned MS_MAX    = 59,
    parameter logic [31:0] TIMEOUT   = 32'd500000,
    parameter logic [31:0] BLINK_DIV = 32'd25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_set,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_cancel,
    input  logic [4:0] cur_hrs,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [2:0] mode,
    output logic [5:0] val,
    output logic       switch,
    output logic       editing,
    output logic       blink
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEC   = 3'd1,
        S_MIN   = 3'd2,
        S_HRS   = 3'd3,
        S_APPLY = 3'd4
    } state_t;

    localparam logic [5:0]  HR_MAX_V = 6'(HR_MAX);
    localparam logic [5:0]  MS_MAX_V = 6'(MS_MAX);
    localparam logic [31:0] TO_LAST  = TIMEOUT - 32'd1;

    state_t      state_q, state_d;
    logic [2:0]  mode_q, mode_d;
    logic [5:0]  val_q, val_d;
    logic        switch_q, switch_d;
    logic        editing_q, editing_d;
    logic [31:0] to_cnt_q, to_cnt_d;

    logic        any_btn;
    logic        in_edit;
    logic        timed_out;
    logic [5:0]  field_max;

    // Increment with wrap. Using >= lets an out-of-range preload wrap to 0.
    function automatic logic [5:0] wrap_up(input logic [5:0] v, input logic [5:0] mx);
        return (v >= mx) ? 6'd0 : v + 6'd1;
    endfunction

    // Decrement with wrap. An out-of-range preload simply steps down by one.
    function automatic logic [5:0] wrap_dn(input logic [5:0] v, input logic [5:0] mx);
        return (v == 6'd0) ? mx : v - 6'd1;
    endfunction

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        any_btn   = btn_set | btn_next | btn_up | btn_down | btn_cancel;
        in_edit   = (state_q == S_SEC) || (state_q == S_MIN) || (state_q == S_HRS);
        timed_out = in_edit && (to_cnt_q == TO_LAST);
        field_max = (state_q == S_HRS) ? HR_MAX_V : MS_MAX_V;

        case (state_q)
            S_IDLE: begin
                if (btn_set) begin
                    state_d = S_SEC;
                    val_d   = cur_sec;
                end else begin
                    val_d   = 6'd0;
                end
            end
            S_SEC, S_MIN, S_HRS: begin
                // Timeout is treated exactly like a cancel and outranks every button.
                if (btn_cancel || timed_out) begin
                    state_d = S_IDLE;
                    val_d   = 6'd0;
                end else if (btn_next) begin
                    case (state_q)
                        S_SEC: begin
                            state_d = S_MIN;
                            val_d   = cur_min;
                        end
                        S_MIN: begin
                            state_d = S_HRS;
                            val_d   = {1'b0, cur_hrs};
                        end
                        default: begin
                            state_d = S_APPLY;
                            val_d   = 6'd0;
                        end
                    endcase
                end else if (btn_up && !btn_down) begin
                    val_d = wrap_up(val_q, field_max);
                end else if (btn_down && !btn_up) begin
                    val_d = wrap_dn(val_q, field_max);
                end
            end
            S_APPLY: begin
                state_d = S_IDLE;
                val_d   = 6'd0;
            end
            default: begin
                state_d = S_IDLE;
                val_d   = 6'd0;
            end
        endcase

        // The idle counter runs only while an edit state is held with no button.
        // Any pulse or any state change restarts it. In IDLE/APPLY it sits at 0.
        if (in_edit && (state_d == state_q) && !any_btn) begin
            to_cnt_d = to_cnt_q + 32'd1;
        end else begin
            to_cnt_d = 32'd0;
        end

        // The outputs are derived from the next state so they line up with it once registered.
        mode_d    = 3'd0;
        editing_d = 1'b0;
        case (state_d)
            S_SEC: begin
                mode_d    = 3'd1;
                editing_d = 1'b1;
            end
            S_MIN: begin
                mode_d    = 3'd2;
                editing_d = 1'b1;
            end
            S_HRS: begin
                mode_d    = 3'd3;
                editing_d = 1'b1;
            end
            default: begin
                mode_d    = 3'd0;
                editing_d = 1'b0;
            end
        endcase
        switch_d = (state_d == S_APPLY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 3'd0;
            val_q     <= 6'd0;
            switch_q  <= 1'b0;
            editing_q <= 1'b0;
            to_cnt_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            val_q     <= val_d;
            switch_q  <= switch_d;
            editing_q <= editing_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign mode    = mode_q;
    assign val     = val_q;
    assign switch  = switch_q;
    assign editing = editing_q;

`ifdef BLINK_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;
    logic        blink_q, blink_d;

    // An up/down press forces the field solid so the operator sees the new value.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        blink_d   = blink_q;
        if (!editing_d || btn_up || btn_down) begin
            blk_cnt_d = 32'd0;
            blink_d   = 1'b0;
        end else if (blk_cnt_q == (BLINK_DIV - 32'd1)) begin
            blk_cnt_d = 32'd0;
            blink_d   = ~blink_q;
        end else begin
            blk_cnt_d = blk_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= 32'd0;
            blink_q   <= 1'b0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            blink_q   <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = ^BLINK_DIV;
    assign blink = 1'b0;
`endif

endmodule
